// File: rtl/mcpu_prog_loader.sv
// mcpu_prog_loader: streams instruction words into the MCPU RAM write port
// at a chosen base address, optionally zero-filling the RAM first, and holds
// the MCPU in reset until the image is complete.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN. When it is defined, one
// trailing XOR checksum word is checked before the MCPU is released.
module mcpu_prog_loader #(
    parameter int WORD_SIZE     = 16,
    parameter int ADDR_WIDTH    = 8,
    parameter int CLEAR_ON_LOAD = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_abort,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  in_valid,
    input  logic [WORD_SIZE-1:0]  in_data,
    output logic                  in_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WORD_SIZE-1:0]  ram_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    // RAM_SIZE expressed in the length width (a one followed by zeros)
    localparam logic [ADDR_WIDTH:0]   RAM_SIZE_W = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = {ADDR_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_CHECK, S_RUN, S_ERROR
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   base_reg, base_next;
    logic [ADDR_WIDTH:0]     len_reg, len_next;
    logic [ADDR_WIDTH:0]     hs_reg, hs_next;       // handshakes taken so far
    logic [ADDR_WIDTH-1:0]   clr_reg, clr_next;     // zero-fill address
    logic                    ram_we_reg, ram_we_next;
    logic [ADDR_WIDTH-1:0]   ram_addr_reg, ram_addr_next;
    logic [WORD_SIZE-1:0]    ram_wdata_reg, ram_wdata_next;
    logic [ADDR_WIDTH:0]     wc_reg, wc_next;
    logic                    cpu_reset_reg, cpu_reset_next;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [WORD_SIZE-1:0]    acc_reg, acc_next;
    localparam state_t       S_AFTER_LOAD = S_CHECK;
`else
    localparam state_t       S_AFTER_LOAD = S_RUN;
`endif

    logic hs;

    // Stream acceptance and status decode from the current state
    always_comb begin
        in_ready = (state_reg == S_LOAD) && (hs_reg != len_reg);
`ifdef PROG_LOADER_CHECKSUM_EN
        if (state_reg == S_CHECK) begin
            in_ready = 1'b1;
        end
`endif
        busy  = (state_reg == S_CLEAR) || (state_reg == S_LOAD) || (state_reg == S_CHECK);
        done  = (state_reg == S_RUN);
        error = (state_reg == S_ERROR);
    end

    assign hs = in_valid & in_ready;

    // Next-state and next-register computation
    always_comb begin
        state_next     = state_reg;
        base_next      = base_reg;
        len_next       = len_reg;
        hs_next        = hs_reg;
        clr_next       = clr_reg;
        ram_we_next    = 1'b0;
        ram_addr_next  = ram_addr_reg;
        ram_wdata_next = ram_wdata_reg;
        wc_next        = wc_reg;
`ifdef PROG_LOADER_CHECKSUM_EN
        acc_next       = acc_reg;
`endif
        case (state_reg)
            S_IDLE, S_RUN, S_ERROR: begin
                if (load_start) begin
                    base_next  = load_base;
                    len_next   = (load_len > RAM_SIZE_W) ? RAM_SIZE_W : load_len;
                    hs_next    = '0;
                    clr_next   = '0;
                    wc_next    = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    acc_next   = '0;
`endif
                    state_next = (CLEAR_ON_LOAD != 0) ? S_CLEAR : S_LOAD;
                end
            end
            S_CLEAR: begin
                ram_we_next    = 1'b1;
                ram_addr_next  = clr_reg;
                ram_wdata_next = '0;
                clr_next       = clr_reg + 1'b1;
                if (clr_reg == LAST_ADDR) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (len_reg == '0) begin
                    state_next = S_AFTER_LOAD;
                end else if (hs) begin
                    ram_we_next    = 1'b1;
                    ram_addr_next  = base_reg + hs_reg[ADDR_WIDTH-1:0];
                    ram_wdata_next = in_data;
                    hs_next        = hs_reg + 1'b1;
                    wc_next        = wc_reg + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    acc_next       = acc_reg ^ in_data;
`endif
                    // leave on the last handshake so the final write and
                    // the RUN entry coincide; reset drops a cycle later
                    if ((hs_reg + 1'b1) == len_reg) begin
                        state_next = S_AFTER_LOAD;
                    end
                end
            end
            S_CHECK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                if (hs) begin
                    state_next = (in_data == acc_reg) ? S_RUN : S_ERROR;
                end
`else
                state_next = S_RUN;
`endif
            end
            default: state_next = S_IDLE;
        endcase

        // abort wins over any same-cycle handshake: the word is dropped
        if (load_abort && busy) begin
            state_next     = S_IDLE;
            ram_we_next    = 1'b0;
            ram_addr_next  = ram_addr_reg;
            ram_wdata_next = ram_wdata_reg;
            hs_next        = hs_reg;
            wc_next        = wc_reg;
`ifdef PROG_LOADER_CHECKSUM_EN
            acc_next       = acc_reg;
`endif
        end

        // MCPU leaves reset only once RUN has been held for a full cycle
        cpu_reset_next = !((state_reg == S_RUN) && (state_next == S_RUN));
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            base_reg      <= '0;
            len_reg       <= '0;
            hs_reg        <= '0;
            clr_reg       <= '0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            wc_reg        <= '0;
            cpu_reset_reg <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            acc_reg       <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            base_reg      <= base_next;
            len_reg       <= len_next;
            hs_reg        <= hs_next;
            clr_reg       <= clr_next;
            ram_we_reg    <= ram_we_next;
            ram_addr_reg  <= ram_addr_next;
            ram_wdata_reg <= ram_wdata_next;
            wc_reg        <= wc_next;
            cpu_reset_reg <= cpu_reset_next;
`ifdef PROG_LOADER_CHECKSUM_EN
            acc_reg       <= acc_next;
`endif
        end
    end

    assign ram_we     = ram_we_reg;
    assign ram_addr   = ram_addr_reg;
    assign ram_wdata  = ram_wdata_reg;
    assign word_count = wc_reg;
    assign cpu_reset  = cpu_reset_reg;

endmodule

// File: tb/tb_mcpu_prog_loader.sv
// Scoreboard bench for mcpu_prog_loader: stimulus pushes expected RAM writes,
// a negedge monitor pops and compares every ram_we pulse.
module tb_mcpu_prog_loader;
    localparam int WS = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start, load_abort;
    logic [AW-1:0] load_base;
    logic [AW:0]   load_len;
    logic          in_valid;
    logic [WS-1:0] in_data;
    logic          in_ready, ram_we, cpu_reset, busy, done, error;
    logic [AW-1:0] ram_addr;
    logic [WS-1:0] ram_wdata;
    logic [AW:0]   word_count;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [WS-1:0] d;
    } wr_t;

    wr_t           exp_q[$];
    int            checks   = 0;
    int            failures = 0;
    logic [WS-1:0] xacc;

    always #5 clk = ~clk;

    mcpu_prog_loader #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .CLEAR_ON_LOAD(1)) dut (
        .clk(clk), .reset(rst), .load_start(load_start), .load_abort(load_abort),
        .load_base(load_base), .load_len(load_len), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .cpu_reset(cpu_reset),
        .busy(busy), .done(done), .error(error), .word_count(word_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // Monitor: every RAM write must match the head of the scoreboard
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (!rst && ram_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write actual=addr 0x%0h data 0x%0h required=no write",
                             ram_addr, ram_wdata);
                end else begin
                    w = exp_q.pop_front();
                    if (ram_addr !== w.a || ram_wdata !== w.d) begin
                        failures++;
                        $display("FAIL ram_write actual=addr 0x%0h data 0x%0h required=addr 0x%0h data 0x%0h",
                                 ram_addr, ram_wdata, w.a, w.d);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [AW-1:0] b, input logic [AW:0] n);
        wr_t w;
        load_start = 1'b1;
        load_base  = b;
        load_len   = n;
        tick();
        load_start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("cpu_reset_after_start", 32'(cpu_reset), 32'd1);
        chk("done_after_start", 32'(done), 32'd0);
        for (int i = 0; i < 256; i++) begin
            w.a = AW'(i);
            w.d = '0;
            exp_q.push_back(w);
        end
        xacc = '0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 2000) begin
            tick();
            n++;
        end
        chk("in_ready_for_word", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [WS-1:0] d);
        wr_t w;
        in_valid = 1'b1;
        in_data  = d;
        wait_ready();
        w.a = a;
        w.d = d;
        if (in_ready) exp_q.push_back(w);
        xacc ^= d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_check();
`ifdef PROG_LOADER_CHECKSUM_EN
        in_valid = 1'b1;
        in_data  = xacc;
        wait_ready();
        tick();
        in_valid = 1'b0;
`endif
    endtask

    task automatic finish_run(input int n);
        send_check();
        chk("cpu_reset_held_at_last_write", 32'(cpu_reset), 32'd1);
        tick();
        chk("cpu_reset_released", 32'(cpu_reset), 32'd0);
        chk("done_in_run", 32'(done), 32'd1);
        chk("busy_in_run", 32'(busy), 32'd0);
        chk("error_in_run", 32'(error), 32'd0);
        chk("in_ready_in_run", 32'(in_ready), 32'd0);
        chk("word_count", 32'(word_count), 32'(n));
        chk("writes_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_start = 1'b0; load_abort = 1'b0; load_base = '0;
        load_len = '0; in_valid = 1'b0; in_data = '0;
        repeat (3) tick();
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        rst = 1'b0;
        tick();

        // 1: 8-word program at base 0
        start_load(8'h00, 9'd8);
        send(8'h00, 16'h0844); send(8'h01, 16'h0912); send(8'h02, 16'h1201);
        send(8'h03, 16'h2310); send(8'h04, 16'h3402); send(8'h05, 16'h4500);
        send(8'h06, 16'h5607); send(8'h07, 16'hF000);
        finish_run(8);

        // 2: address wrap from 0xFE
        start_load(8'hFE, 9'd4);
        send(8'hFE, 16'hAAAA); send(8'hFF, 16'hBBBB);
        send(8'h00, 16'hCCCC); send(8'h01, 16'hDDDD);
        finish_run(4);

        // 3: in_valid gaps 1/0/0/1...
        start_load(8'h30, 9'd5);
        send(8'h30, 16'h0101); tick(); tick();
        send(8'h31, 16'h0202); tick(); tick();
        send(8'h32, 16'h0303); tick(); tick();
        send(8'h33, 16'h0404); tick(); tick();
        send(8'h34, 16'h0505);
        finish_run(5);

        // 4a: zero-length load writes nothing beyond the clear
        start_load(8'h10, 9'd0);
        send_check();
        for (int i = 0; i < 400 && !done; i++) tick();
        chk("len0_done", 32'(done), 32'd1);
        tick();
        chk("len0_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("len0_word_count", 32'(word_count), 32'd0);
        chk("len0_no_writes", 32'(exp_q.size()), 32'd0);

        // 4b: len=300 saturates to 256 words
        start_load(8'h80, 9'd300);
        for (int i = 0; i < 256; i++) send(AW'(8'h80 + i), WS'(i * 3 + 1));
        finish_run(256);

        // 5a: abort after 3 of 8, with a same-cycle word that must be dropped
        start_load(8'h20, 9'd8);
        send(8'h20, 16'h1234); send(8'h21, 16'h5678); send(8'h22, 16'h9ABC);
        in_valid = 1'b1; in_data = 16'hDEAD; load_abort = 1'b1;
        tick();
        load_abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_word_count", 32'(word_count), 32'd3);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        tick(); tick();
        chk("abort_no_extra_write", 32'(exp_q.size()), 32'd0);

        // 5b: reset in the middle of CLEAR
        start_load(8'h00, 9'd4);
        repeat (10) tick();
        rst = 1'b1;
        #2;
        chk("midrst_ram_we", 32'(ram_we), 32'd0);
        chk("midrst_ram_addr", 32'(ram_addr), 32'd0);
        chk("midrst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("midrst_word_count", 32'(word_count), 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();

`ifdef PROG_LOADER_CHECKSUM_EN
        // 6: checksum match then mismatch
        start_load(8'h40, 9'd2);
        send(8'h40, 16'h1111); send(8'h41, 16'h2222);
        xacc = 16'h3333;
        finish_run(2);
        start_load(8'h40, 9'd2);
        send(8'h40, 16'h1111); send(8'h41, 16'h2222);
        in_valid = 1'b1; in_data = 16'h3334;
        wait_ready();
        tick();
        in_valid = 1'b0;
        tick();
        chk("cksum_error", 32'(error), 32'd1);
        chk("cksum_err_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("cksum_err_done", 32'(done), 32'd0);
`endif

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
